// File: rtl/vga_out_conditioner.sv
// vga_out_conditioner: output-side sync/video conditioner behind the scan doubler.
// Learns the incoming hsync/vsync polarities, delays vsync by one line so it
// lines up with hsync leading edges, and opens a programmable active window.
// Handshake: none; ce_pix is a plain enable and every register holds while it is low.
module vga_out_conditioner #(
  parameter logic [10:0] H_START    = 11'd144,
  parameter logic [10:0] H_END      = 11'd784,
  parameter logic [9:0]  V_START    = 10'd35,
  parameter logic [9:0]  V_END      = 10'd515,
  parameter logic        HS_OUT_POL = 1'b0,
  parameter logic        VS_OUT_POL = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic [8:0] video_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic [8:0] video_out,
  output logic       blank_n
);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Stage 1 capture and previous samples for edge detection
  logic       hs_s1_q, vs_s1_q, hs_prev_q, vs_prev_q, hs_act_prev_q;
  logic [8:0] video_s1_q;

  // Polarity learning
  logic [10:0] hhi_q, hhi_d, hlo_q, hlo_d;
  logic [9:0]  vhi_q, vhi_d, vlo_q, vlo_d;
  logic        hpol_q, hpol_d, vpol_q, vpol_d;

  // Vsync line delay and raster counters
  logic        vs_smp_q, vs_smp_d, vs_dly_q, vs_dly_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;

  // Stage 2 outputs
  logic       hs_out_q, hs_out_d, vs_out_q, vs_out_d, blank_n_q, blank_n_d;
  logic [8:0] video_out_q, video_out_d;

  logic hs_rise, vs_rise, hs_act, vs_act, hle, act;

  assign hs_rise = hs_s1_q & ~hs_prev_q;
  assign vs_rise = vs_s1_q & ~vs_prev_q;
  // Normalized syncs: 1 while the sync pulse is asserted, whatever the input polarity
  assign hs_act  = ~(hs_s1_q ^ hpol_q);
  assign vs_act  = ~(vs_s1_q ^ vpol_q);
  assign hle     = hs_act & ~hs_act_prev_q;

  // Polarity detection: the shorter phase between raw rising edges is the sync pulse
  always_comb begin
    hhi_d  = hhi_q;
    hlo_d  = hlo_q;
    hpol_d = hpol_q;
    vhi_d  = vhi_q;
    vlo_d  = vlo_q;
    vpol_d = vpol_q;
    if (hs_rise) begin
      if (hhi_q != hlo_q) hpol_d = (hhi_q < hlo_q);
      hhi_d = '0;
      hlo_d = '0;
    end else if (hs_s1_q) begin
      hhi_d = sat_inc11(hhi_q);
    end else begin
      hlo_d = sat_inc11(hlo_q);
    end
    if (vs_rise) begin
      if (vhi_q != vlo_q) vpol_d = (vhi_q < vlo_q);
      vhi_d = '0;
      vlo_d = '0;
    end else if (hle) begin
      if (vs_s1_q) vhi_d = sat_inc10(vhi_q);
      else         vlo_d = sat_inc10(vlo_q);
    end
  end

  // One-line vsync delay, raster counters and the active window on updated counts
  always_comb begin
    vs_smp_d = vs_smp_q;
    vs_dly_d = vs_dly_q;
    hcnt_d   = sat_inc11(hcnt_q);
    vcnt_d   = vcnt_q;
    if (hle) begin
      vs_smp_d = vs_act;
      vs_dly_d = vs_smp_q;
      hcnt_d   = '0;
      // A delayed-vsync rising edge starts a new frame; clear beats increment
      vcnt_d   = (vs_smp_q & ~vs_dly_q) ? '0 : sat_inc10(vcnt_q);
    end
    act = (hcnt_d >= H_START) && (hcnt_d < H_END) &&
          (vcnt_d >= V_START) && (vcnt_d < V_END);
    hs_out_d    = hs_act   ? HS_OUT_POL : ~HS_OUT_POL;
    vs_out_d    = vs_dly_d ? VS_OUT_POL : ~VS_OUT_POL;
    blank_n_d   = act;
    video_out_d = act ? video_s1_q : 9'h000;
  end

  // All state advances on pixel strobes only; reset is immediate
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      hs_act_prev_q <= 1'b0;
      video_s1_q    <= '0;
      hhi_q         <= '0;
      hlo_q         <= '0;
      vhi_q         <= '0;
      vlo_q         <= '0;
      hpol_q        <= 1'b0;
      vpol_q        <= 1'b0;
      vs_smp_q      <= 1'b0;
      vs_dly_q      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hs_out_q      <= ~HS_OUT_POL;
      vs_out_q      <= ~VS_OUT_POL;
      blank_n_q     <= 1'b0;
      video_out_q   <= '0;
    end else if (ce_pix) begin
      hs_s1_q       <= hs_in;
      vs_s1_q       <= vs_in;
      hs_prev_q     <= hs_s1_q;
      vs_prev_q     <= vs_s1_q;
      hs_act_prev_q <= hs_act;
      video_s1_q    <= video_in;
      hhi_q         <= hhi_d;
      hlo_q         <= hlo_d;
      vhi_q         <= vhi_d;
      vlo_q         <= vlo_d;
      hpol_q        <= hpol_d;
      vpol_q        <= vpol_d;
      vs_smp_q      <= vs_smp_d;
      vs_dly_q      <= vs_dly_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hs_out_q      <= hs_out_d;
      vs_out_q      <= vs_out_d;
      blank_n_q     <= blank_n_d;
      video_out_q   <= video_out_d;
    end
  end

  assign hs_out    = hs_out_q;
  assign vs_out    = vs_out_q;
  assign blank_n   = blank_n_q;
  assign video_out = video_out_q;

endmodule

// File: tb/tb_vga_out_conditioner.sv
// Bench for vga_out_conditioner on a reduced 40x20 raster (sync 6 pixels / 2 lines).
// Expected outputs come from raster geometry: pixel x, line y, and the rule that
// the window and vsync output follow the line before the current one.
module tb_vga_out_conditioner;

  localparam int HT = 40, HW = 6, VT = 20, VSW = 2;
  localparam int HS = 10, HE = 34, VS = 4, VE = 16;
  localparam int FR = HT * VT;
  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b0;

  logic       clk, reset, ce_pix, hs_in, vs_in;
  logic [8:0] video_in;
  logic       hs_out, vs_out, blank_n;
  logic [8:0] video_out;

  vga_out_conditioner #(
    .H_START(11'(HS)), .H_END(11'(HE)), .V_START(10'(VS)), .V_END(10'(VE)),
    .HS_OUT_POL(HS_POL), .VS_OUT_POL(VS_POL)
  ) dut (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hs_in(hs_in), .vs_in(vs_in),
    .video_in(video_in), .hs_out(hs_out), .vs_out(vs_out),
    .video_out(video_out), .blank_n(blank_n)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {chk_hs, chk_vs, chk_win, hs, vs, blank_n, video[8:0]}
  logic [14:0] exp_q[$];
  logic [14:0] cur_e;
  logic        have_last = 1'b0;
  int errors = 0, checks = 0;
  int g = 0;
  int ce_div = 1;
  bit in_high = 0, vid_mode = 0, hs_stop = 0;
  int model_act = 0, dut_act = 0, dut_hs = 0, dut_vs = 0;

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic check_entry(input logic [14:0] e, input string tag);
    if (e[14]) chk({"hs_out", tag}, int'(hs_out), int'(e[11]));
    if (e[13]) chk({"vs_out", tag}, int'(vs_out), int'(e[10]));
    if (e[12]) begin
      chk({"blank_n", tag}, int'(blank_n), int'(e[9]));
      chk({"video_out", tag}, int'(video_out), int'(e[8:0]));
    end
  endtask

  // Compare process: outputs after strobe k belong to the sample driven before strobe k-1
  always @(posedge clk) begin : cmp
    logic ce_s, rst_s;
    ce_s  = ce_pix;
    rst_s = reset;
    #1;
    if (!rst_s && !reset) begin
      if (ce_s) begin
        if (exp_q.size() >= 2) begin
          cur_e = exp_q.pop_front();
          have_last = 1'b1;
          check_entry(cur_e, "");
          if (blank_n) dut_act++;
          if (hs_out == HS_POL) dut_hs++;
          if (vs_out == VS_POL) dut_vs++;
        end
      end else if (have_last) begin
        check_entry(cur_e, "_hold");
      end
    end
  end

  // Driver: one pixel strobe, preceded by ce_div-1 idle clocks
  task automatic drive_strobe(input bit chk_on);
    int x, y, yv;
    logic hs_a, vs_a, win;
    logic [8:0] vid;
    logic [14:0] e;
    for (int i = 1; i < ce_div; i++) begin
      @(negedge clk);
      ce_pix = 1'b0;
    end
    @(negedge clk);
    x  = g % HT;
    y  = (g / HT) % VT;
    yv = (y + VT - 1) % VT;
    hs_a = !hs_stop && (x < HW);
    vs_a = (y < VSW);
    win  = (x >= HS) && (x < HE) && (yv >= VS) && (yv < VE);
    vid  = vid_mode ? 9'h1FF : 9'((g * 37 + 11) % 512);
    hs_in    = in_high ? hs_a : ~hs_a;
    vs_in    = in_high ? vs_a : ~vs_a;
    video_in = vid;
    ce_pix   = 1'b1;
    if (hs_stop)
      e = {3'b101, ~HS_POL, 1'b0, 1'b0, 9'h000};
    else
      e = {chk_on, chk_on, chk_on, (hs_a ? HS_POL : ~HS_POL),
           ((yv < VSW) ? VS_POL : ~VS_POL), win, (win ? vid : 9'h000)};
    if (!hs_stop && win) model_act++;
    exp_q.push_back(e);
    g++;
  endtask

  task automatic run_strobes(input int n, input int chk_start);
    for (int i = 0; i < n; i++) drive_strobe(i >= chk_start);
  endtask

  task automatic finish_frame();
    while ((g % FR) != 0) drive_strobe(1'b0);
  endtask

  int a0, h0, v0, m0;

  initial begin
    reset = 1'b1; ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; video_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_hs_out", int'(hs_out), 0);
    chk("rst_vs_out", int'(vs_out), 1);
    chk("rst_blank_n", int'(blank_n), 0);
    chk("rst_video_out", int'(video_out), 0);
    reset = 1'b0;

    // Active-low syncs, constant white video, strobe every clock
    in_high = 0; vid_mode = 1; ce_div = 1;
    run_strobes(3 * FR, 2 * FR + HT);
    a0 = dut_act; h0 = dut_hs; v0 = dut_vs; m0 = model_act;
    run_strobes(FR, 0);
    chk("frame_active_strobes", dut_act - a0, 288);
    chk("model_active_strobes", model_act - m0, 288);
    chk("frame_hs_strobes", dut_hs - h0, 120);
    chk("frame_vs_strobes", dut_vs - v0, 80);

    // Strobe on every third clock, outputs must hold in between
    vid_mode = 0; ce_div = 3;
    run_strobes(2 * FR, 0);

    // Active-high syncs with the same geometry
    ce_div = 1; in_high = 1;
    run_strobes(5 * FR, 3 * FR + HT);

    // Reset pulsed mid-line
    run_strobes(20, 0);
    @(negedge clk);
    ce_pix = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_hs_out", int'(hs_out), 0);
    chk("midrst_vs_out", int'(vs_out), 1);
    chk("midrst_blank_n", int'(blank_n), 0);
    chk("midrst_video_out", int'(video_out), 0);
    exp_q.delete();
    have_last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    finish_frame();
    run_strobes(3 * FR, FR + HT);

    // Hsync held static for 3000 strobes while the window would be open
    run_strobes(8 * HT, 0);
    hs_stop = 1;
    run_strobes(3000, 0);
    hs_stop = 0;
    finish_frame();
    run_strobes(2 * FR, HT);

    @(negedge clk);
    ce_pix = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
